// File: rtl/puf_response_collector_if.sv
// Bus between the PUF response collector and its environment: request, challenge/response, result.
interface puf_response_collector_if;
  localparam int unsigned CHAL_W = 64;
  localparam int unsigned ID_W   = 32;

  logic              start;
  logic [CHAL_W-1:0] seed;
  logic [CHAL_W-1:0] challenge;
  logic              response;
  logic              busy;
  logic              done;
  logic [ID_W-1:0]   id_out;
  logic              id_valid;

  // Environment side: issues requests, models the arbiter PUF, consumes the ID.
  modport master (
    output start, seed, response,
    input  challenge, busy, done, id_out, id_valid
  );

  // Collector side.
  modport slave (
    input  start, seed, response,
    output challenge, busy, done, id_out, id_valid
  );
endinterface

// File: rtl/puf_response_collector.sv
// Arbiter-PUF response collector: walks a 64-bit Galois LFSR of challenges, lets each
// challenge settle, samples the PUF response and packs 32 extracted bits into an ID.
// Build option: define PUF_MAJORITY_VOTE_EN to take VOTES samples per challenge and
// majority-vote them; otherwise a single sample per challenge is used directly.
module puf_response_collector #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned VOTES         = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  puf_response_collector_if.slave  if_bus
);

  localparam int unsigned CHAL_W    = 64;
  localparam int unsigned ID_W      = 32;
  localparam int unsigned BIT_CNT_W = 5;
  localparam int unsigned SETTLE_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned VOTE_W    = $clog2(VOTES + 1);
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int unsigned VOTES_EFF = VOTES;
`else
  localparam int unsigned VOTES_EFF = 1;
`endif
  // x^64+x^63+x^61+x^60+1 in right-shifting Galois form.
  localparam logic [CHAL_W-1:0] LFSR_TAPS = 64'hD800000000000000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    SHIFT  = 3'd4,
    DONE   = 3'd5
  } state_e;

  state_e                r_state;
  state_e                w_next_state;
  logic [CHAL_W-1:0]     r_lfsr;
  logic [SETTLE_W-1:0]   r_settle_cnt;
  logic [VOTE_W-1:0]     r_vote_cnt;
  logic [VOTE_W-1:0]     r_ones;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [ID_W-1:0]       r_shift;
  logic [ID_W-1:0]       r_id_out;
  logic                  r_id_valid;
  logic                  r_done;
  logic                  r_busy;

  logic                  w_accept;
  logic                  w_sample;
  logic                  w_shift;
  logic                  w_finish;
  logic                  w_settle_last;
  logic                  w_votes_last;
  logic                  w_bit_last;
  logic                  w_bit_value;
  logic [CHAL_W-1:0]     w_seed_eff;
  logic [CHAL_W-1:0]     w_lfsr_step;

  assign w_settle_last = (r_settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1));
  assign w_votes_last  = (r_vote_cnt == VOTE_W'(VOTES_EFF - 1));
  assign w_bit_last    = (r_bit_cnt == BIT_CNT_W'(ID_W - 1));
  assign w_bit_value   = (r_ones > VOTE_W'(VOTES_EFF / 2));
  assign w_seed_eff    = (if_bus.seed == '0) ? CHAL_W'(1) : if_bus.seed;
  assign w_lfsr_step   = {1'b0, r_lfsr[CHAL_W-1:1]} ^ (r_lfsr[0] ? LFSR_TAPS : '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and per-state datapath strobes.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_sample     = 1'b0;
    w_shift      = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (if_bus.start) begin
          w_accept     = 1'b1;
          w_next_state = LOAD;
        end
      end
      LOAD: begin
        w_next_state = SETTLE;
      end
      SETTLE: begin
        if (w_settle_last) begin
          w_next_state = SAMPLE;
        end
      end
      SAMPLE: begin
        w_sample     = 1'b1;
        w_next_state = w_votes_last ? SHIFT : SETTLE;
      end
      SHIFT: begin
        w_shift      = 1'b1;
        w_next_state = w_bit_last ? DONE : SETTLE;
      end
      DONE: begin
        w_finish     = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Settle timer: counts cycles spent in SETTLE, restarts on every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_settle_cnt <= '0;
    end else if ((r_state == SETTLE) && !w_settle_last) begin
      r_settle_cnt <= r_settle_cnt + SETTLE_W'(1);
    end else begin
      r_settle_cnt <= '0;
    end
  end

  // Vote tally for the current challenge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vote_cnt <= '0;
      r_ones     <= '0;
    end else if (w_accept || w_shift) begin
      r_vote_cnt <= '0;
      r_ones     <= '0;
    end else if (w_sample) begin
      r_vote_cnt <= r_vote_cnt + VOTE_W'(1);
      r_ones     <= r_ones + VOTE_W'(if_bus.response);
    end
  end

  // ID shift register and bit counter; first extracted bit ends up in the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (w_accept) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (w_shift) begin
      r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
      r_shift   <= {r_shift[ID_W-2:0], w_bit_value};
    end
  end

  // Challenge LFSR: seeded on accept, advanced once per extracted bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= '0;
    end else if (w_accept) begin
      r_lfsr <= w_seed_eff;
    end else if (w_shift) begin
      r_lfsr <= w_lfsr_step;
    end
  end

  // Result registers: held between extractions, valid dropped on a new request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_out   <= '0;
      r_id_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_id_valid <= 1'b0;
      end else if (w_finish) begin
        r_id_out   <= r_shift;
        r_id_valid <= 1'b1;
      end
    end
  end

  // Busy tracks any non-IDLE state, aligned with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_next_state != IDLE);
    end
  end

  assign if_bus.challenge = r_lfsr;
  assign if_bus.busy      = r_busy;
  assign if_bus.done      = r_done;
  assign if_bus.id_out    = r_id_out;
  assign if_bus.id_valid  = r_id_valid;

endmodule

// File: tb/tb_puf_response_collector.sv
// Self-checking bench for puf_response_collector with a parity-model arbiter PUF.
`timescale 1ns/1ps
module tb_puf_response_collector;

  localparam int SETTLE = 4;
  localparam int VOTES  = 5;
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int NV = VOTES;
`else
  localparam int NV = 1;
`endif
  localparam int BIT_LEN = NV * (SETTLE + 1) + 1;
  localparam int LAT     = 1 + 32 * BIT_LEN + 1;
  localparam int TAIL    = 8;
  localparam logic [63:0] NOM_SEED = 64'hA5A5A5A5A5A5A5A5;

  logic clk = 1'b0;
  logic rst;
  logic flip;
  int   n_cmp = 0;
  int   n_bad = 0;

  puf_response_collector_if bus();

  // Arbiter PUF model: parity of the challenge, optionally inverted by the noise injector.
  assign bus.response = (^bus.challenge) ^ flip;

  puf_response_collector #(.SETTLE_CYCLES(SETTLE), .VOTES(VOTES)) dut (
    .clk    (clk),
    .rst    (rst),
    .if_bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    logic [63:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 64'hD800000000000000;
    return r;
  endfunction

  function automatic logic [31:0] model_id(input logic [63:0] seed);
    logic [63:0] s;
    logic [31:0] id;
    s  = (seed == 64'd0) ? 64'd1 : seed;
    id = '0;
    for (int i = 0; i < 32; i++) begin
      id[31-i] = ^s;
      s = lfsr_next(s);
    end
    return id;
  endfunction

  // Runs one extraction and records what was observed, window by window after the start edge.
  task automatic run_extraction(
    input  logic [63:0] seed, input bit noisy, input int glitch_j,
    output int done_j, output int done_cnt, output logic [31:0] id_seen,
    output logic valid_seen, output logic valid_j0, output int busy_err,
    output int chal_err, output logic [63:0] chal_j0, output logic [63:0] chal_b1);
    logic [63:0] st [33];
    logic [15:0] mask [32];
    logic [63:0] exp_chal;
    int b, p, nflip;
    st[0] = (seed == 64'd0) ? 64'd1 : seed;
    for (int i = 1; i < 33; i++) st[i] = lfsr_next(st[i-1]);
    for (int i = 0; i < 32; i++) begin
      mask[i] = '0;
      nflip = 0;
      while (noisy && nflip < NV / 2) begin
        p = int'($urandom_range(NV - 1, 0));
        if (!mask[i][p]) begin
          mask[i][p] = 1'b1;
          nflip++;
        end
      end
    end
    done_j = -1; done_cnt = 0; busy_err = 0; chal_err = 0;
    id_seen = '0; valid_seen = 1'b0; valid_j0 = 1'b1; chal_j0 = '0; chal_b1 = '0;
    bus.seed  = seed;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int j = 0; j <= LAT + TAIL; j++) begin
      flip = 1'b0;
      if (j > 0) begin
        b = (j - 1) / BIT_LEN;
        p = (j - 1) % BIT_LEN;
        if (b < 32 && p < NV * (SETTLE + 1)) flip = mask[b][p / (SETTLE + 1)];
      end
      if (glitch_j >= 0) begin
        bus.start = (j == glitch_j);
        if (j == glitch_j) bus.seed = ~seed;
      end
      b = (j == 0) ? 0 : (j - 1) / BIT_LEN;
      if (b > 32) b = 32;
      exp_chal = st[b];
      if (bus.challenge !== exp_chal) chal_err++;
      if (bus.busy !== (j < LAT)) busy_err++;
      if (j == 0) begin
        valid_j0 = bus.id_valid;
        chal_j0  = bus.challenge;
      end
      if (j == 1 + BIT_LEN) chal_b1 = bus.challenge;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_j < 0) begin
          done_j     = j;
          id_seen    = bus.id_out;
          valid_seen = bus.id_valid;
        end
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    flip = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.start = 1'b0; bus.seed = '0; flip = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.challenge !== 64'd0) begin n_bad++; $display("FAIL reset_challenge got=%h exp=0", bus.challenge); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    n_cmp++; if (bus.id_out !== 32'd0) begin n_bad++; $display("FAIL reset_id_out got=%h exp=0", bus.id_out); end
    n_cmp++; if (bus.id_valid !== 1'b0) begin n_bad++; $display("FAIL reset_id_valid got=%b exp=0", bus.id_valid); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_nominal;
    logic [63:0] seed;
    int dj, dc, be, ce;
    logic [31:0] id;
    logic v, v0;
    logic [63:0] c0, c1;
    for (int k = 0; k < 4; k++) begin
      seed = (k == 0) ? NOM_SEED : {$urandom, $urandom};
      run_extraction(seed, 1'b0, -1, dj, dc, id, v, v0, be, ce, c0, c1);
      n_cmp++; if (dj !== LAT) begin n_bad++; $display("FAIL nominal_latency seed=%h got=%0d exp=%0d", seed, dj, LAT); end
      n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL nominal_done_count seed=%h got=%0d exp=1", seed, dc); end
      n_cmp++; if (id !== model_id(seed)) begin n_bad++; $display("FAIL nominal_id seed=%h got=%h exp=%h", seed, id, model_id(seed)); end
      n_cmp++; if (v !== 1'b1) begin n_bad++; $display("FAIL nominal_id_valid seed=%h got=%b exp=1", seed, v); end
      n_cmp++; if (be !== 0) begin n_bad++; $display("FAIL nominal_busy seed=%h bad_cycles=%0d exp=0", seed, be); end
      n_cmp++; if (ce !== 0) begin n_bad++; $display("FAIL nominal_challenge seed=%h bad_cycles=%0d exp=0", seed, ce); end
    end
  endtask

  task automatic test_zero_seed;
    int dj, dc, be, ce;
    logic [31:0] id;
    logic v, v0;
    logic [63:0] c0, c1;
    run_extraction(64'd0, 1'b0, -1, dj, dc, id, v, v0, be, ce, c0, c1);
    n_cmp++; if (c0 !== 64'h0000000000000001) begin n_bad++; $display("FAIL zero_seed_load got=%h exp=0000000000000001", c0); end
    n_cmp++; if (c1 !== 64'hD800000000000000) begin n_bad++; $display("FAIL zero_seed_bit1 got=%h exp=d800000000000000", c1); end
    n_cmp++; if (id !== model_id(64'd0)) begin n_bad++; $display("FAIL zero_seed_id got=%h exp=%h", id, model_id(64'd0)); end
    n_cmp++; if (dj !== LAT) begin n_bad++; $display("FAIL zero_seed_latency got=%0d exp=%0d", dj, LAT); end
  endtask

`ifdef PUF_MAJORITY_VOTE_EN
  task automatic test_noise;
    int dj, dc, be, ce;
    logic [31:0] id;
    logic v, v0;
    logic [63:0] c0, c1;
    run_extraction(NOM_SEED, 1'b1, -1, dj, dc, id, v, v0, be, ce, c0, c1);
    n_cmp++; if (id !== model_id(NOM_SEED)) begin n_bad++; $display("FAIL noise_id got=%h exp=%h", id, model_id(NOM_SEED)); end
    n_cmp++; if (dj !== LAT) begin n_bad++; $display("FAIL noise_latency got=%0d exp=%0d", dj, LAT); end
    n_cmp++; if (ce !== 0) begin n_bad++; $display("FAIL noise_challenge bad_cycles=%0d exp=0", ce); end
  endtask
`endif

  task automatic test_reset_mid;
    logic [63:0] seed;
    int dj, dc, be, ce;
    logic [31:0] id;
    logic v, v0;
    logic [63:0] c0, c1;
    bus.seed  = {$urandom, $urandom};
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before_reset got=%b exp=1", bus.busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.challenge !== 64'd0) begin n_bad++; $display("FAIL mid_reset_challenge got=%h exp=0", bus.challenge); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset_busy got=%b exp=0", bus.busy); end
    n_cmp++; if (bus.id_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_id_valid got=%b exp=0", bus.id_valid); end
    n_cmp++; if (bus.id_out !== 32'd0) begin n_bad++; $display("FAIL mid_reset_id_out got=%h exp=0", bus.id_out); end
    @(negedge clk);
    rst  = 1'b0;
    seed = {$urandom, $urandom};
    run_extraction(seed, 1'b0, -1, dj, dc, id, v, v0, be, ce, c0, c1);
    n_cmp++; if (c0 !== seed) begin n_bad++; $display("FAIL post_reset_accept got=%h exp=%h", c0, seed); end
    n_cmp++; if (dj !== LAT) begin n_bad++; $display("FAIL post_reset_latency got=%0d exp=%0d", dj, LAT); end
    n_cmp++; if (id !== model_id(seed)) begin n_bad++; $display("FAIL post_reset_id got=%h exp=%h", id, model_id(seed)); end
  endtask

  task automatic test_protocol;
    logic [63:0] seed, seed2;
    int dj, dc, be, ce;
    logic [31:0] id;
    logic v, v0;
    logic [63:0] c0, c1;
    seed = {$urandom, $urandom};
    run_extraction(seed, 1'b0, 1 + 10 * BIT_LEN, dj, dc, id, v, v0, be, ce, c0, c1);
    n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL protocol_done_count got=%0d exp=1", dc); end
    n_cmp++; if (dj !== LAT) begin n_bad++; $display("FAIL protocol_latency got=%0d exp=%0d", dj, LAT); end
    n_cmp++; if (id !== model_id(seed)) begin n_bad++; $display("FAIL protocol_id got=%h exp=%h", id, model_id(seed)); end
    n_cmp++; if (ce !== 0) begin n_bad++; $display("FAIL protocol_challenge bad_cycles=%0d exp=0", ce); end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (bus.id_out !== model_id(seed)) begin n_bad++; $display("FAIL hold_id_out got=%h exp=%h", bus.id_out, model_id(seed)); end
    n_cmp++; if (bus.id_valid !== 1'b1) begin n_bad++; $display("FAIL hold_id_valid got=%b exp=1", bus.id_valid); end
    seed2 = {$urandom, $urandom};
    run_extraction(seed2, 1'b0, -1, dj, dc, id, v, v0, be, ce, c0, c1);
    n_cmp++; if (v0 !== 1'b0) begin n_bad++; $display("FAIL restart_valid_drop got=%b exp=0", v0); end
    n_cmp++; if (v !== 1'b1) begin n_bad++; $display("FAIL restart_valid_rise got=%b exp=1", v); end
    n_cmp++; if (id !== model_id(seed2)) begin n_bad++; $display("FAIL restart_id got=%h exp=%h", id, model_id(seed2)); end
    n_cmp++; if (dj !== LAT) begin n_bad++; $display("FAIL restart_latency got=%0d exp=%0d", dj, LAT); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero_seed();
`ifdef PUF_MAJORITY_VOTE_EN
    test_noise();
`endif
    test_reset_mid();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/puf_response_collector.md
PUF_RESPONSE_COLLECTOR -- requirements
Module: puf_response_collector

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4: cycles each challenge is held before the response is sampled; legal range 1..255.
REQ-002 SHALL have parameter VOTES, default 5: number of samples per challenge; odd, legal range 1..15.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request a 32-bit ID extraction; sampled only in IDLE.
REQ-006 SHALL have port seed  input  64  initial challenge, captured when start is accepted.
REQ-007 SHALL have port challenge  output  64  registered challenge driven to the arbiter PUF.
REQ-008 SHALL have port response  input  1  arbiter PUF response bit.
REQ-009 SHALL have port busy  output  1  high from the cycle after start is accepted until the state returns to IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse when id_out is updated.
REQ-011 SHALL have port id_out  output  32  extracted ID; first extracted bit ends up in bit 31.
REQ-012 SHALL have port id_valid  output  1  high when id_out holds a complete ID.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, SETTLE, SAMPLE, SHIFT, DONE.
REQ-014 SHALL, in IDLE with start=1, go to LOAD, capture seed into the 64-bit LFSR (64'h1 if seed==0), clear bit, vote and ones counters, and clear id_valid.
REQ-015 SHALL ignore start in every state except IDLE.
REQ-016 SHALL drive challenge from the LFSR register; LOAD lasts 1 cycle, then SETTLE.
REQ-017 SHALL stay in SETTLE exactly SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-018 SHALL, in SAMPLE (1 cycle), add response to ones counter and increment vote counter; go to SETTLE if votes taken < VOTES, else SHIFT.
REQ-019 SHALL, in SHIFT (1 cycle), compute bit = (ones > VOTES/2), shift it into the ID shift register LSB, advance the LFSR one step, clear vote and ones counters, increment bit counter; go to DONE after the 32nd bit, else SETTLE.
REQ-020 SHALL advance the LFSR as a Galois LFSR with polynomial x^64+x^63+x^61+x^60+1 (shift right; if the bit shifted out is 1, XOR with 64'hD800000000000000).
REQ-021 SHALL, in DONE (1 cycle), load id_out from the shift register, set id_valid=1, pulse done=1, then go to IDLE.
REQ-022 SHALL hold id_out and id_valid unchanged until the next accepted start.
REQ-023 SHALL have a latency of 1 + 32*(VOTES*(SETTLE_CYCLES+1)+1) + 1 cycles from the start-sampling edge to done, i.e. 834 with defaults.
REQ-024 SHALL hold challenge stable throughout SETTLE and SAMPLE of the same bit.

Reset
REQ-025 SHALL, on rst=1 at any time including mid-extraction, immediately force state IDLE, challenge=0, id_out=0, id_valid=0, done=0, busy=0, and clear all counters.
REQ-026 SHALL accept start on the first rising edge after rst deasserts.

Configuration
REQ-027 SHALL, with PUF_MAJORITY_VOTE_EN defined, behave as REQ-018/019 with VOTES samples per challenge.
REQ-028 SHALL, without PUF_MAJORITY_VOTE_EN, take exactly one sample per challenge and use it directly as the bit; VOTES is ignored, and the latency is 1+32*(SETTLE_CYCLES+2)+1 (194 with defaults).

Verification
REQ-029 SHALL cover reset: assert rst mid-SETTLE -> next cycle challenge=0, busy=0, id_valid=0, id_out=0.
REQ-030 SHALL cover nominal: model response=^challenge, seed=64'hA5A5A5A5A5A5A5A5, start -> done at cycle 834, id_out equals the model's parity of 32 successive LFSR states, id_valid=1.
REQ-031 SHALL cover zero seed: seed=0 -> challenge=64'h0000000000000001 in LOAD, and the second bit's challenge=64'hD800000000000000.
REQ-032 SHALL cover noise: model flips response on 2 of 5 votes per challenge -> id_out identical to the noise-free run of REQ-030.
REQ-033 SHALL cover protocol: start pulsed at bit 10 while busy -> ignored, single done at 834; then a new start -> id_valid drops in the next cycle and rises again at done.
REQ-034 SHALL cover the build without PUF_MAJORITY_VOTE_EN: REQ-030 stimulus -> done at cycle 194 with the same id_out.
